// File: rtl/lrsc_reservation_unit.sv
// lrsc_reservation_unit
// Tracks one LR/SC reservation per hart at granule resolution. Each SC gets
// a registered success/fail verdict one cycle after it is presented.
// Reservations are lost to foreign stores, foreign successful SCs, the
// hart's own SC or store, lifetime expiry, and reset.
module lrsc_reservation_unit #(
    parameter int NUM_HARTS    = 2,
    parameter int ADDR_WIDTH   = 32,
    parameter int GRANULE_BITS = 2,
    parameter int TIMEOUT      = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_HARTS-1:0]            req_valid,
    input  logic [2*NUM_HARTS-1:0]          req_op,
    input  logic [ADDR_WIDTH*NUM_HARTS-1:0] req_addr,
    output logic [NUM_HARTS-1:0]            resp_valid,
    output logic [NUM_HARTS-1:0]            sc_success,
    output logic [NUM_HARTS-1:0]            reserved_flag,
    output logic [NUM_HARTS-1:0]            conflict_pulse
);

    localparam int TW = ADDR_WIDTH - GRANULE_BITS;
    // Keep the counter at least one bit wide so TIMEOUT=0 still elaborates
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT);

    localparam logic [1:0] OP_LR = 2'b01;
    localparam logic [1:0] OP_SC = 2'b10;
    localparam logic [1:0] OP_ST = 2'b11;

    logic [NUM_HARTS-1:0] valid_q, valid_d;
    logic [TW-1:0]        tag_q [NUM_HARTS];
    logic [TW-1:0]        tag_d [NUM_HARTS];
    logic [CW-1:0]        cnt_q [NUM_HARTS];
    logic [CW-1:0]        cnt_d [NUM_HARTS];

    logic [TW-1:0]        req_tag [NUM_HARTS];
    logic [NUM_HARTS-1:0] is_lr, is_sc, is_st;
    logic [NUM_HARTS-1:0] sc_ok, sc_win, killer, foreign_kill;

    // Granule bits below the tag never take part in matching
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr;

    // Decode requests and resolve SC arbitration among harts
    always_comb begin
        for (int i = 0; i < NUM_HARTS; i++) begin
            req_tag[i] = req_addr[ADDR_WIDTH*i+GRANULE_BITS +: TW];
            is_lr[i]   = req_valid[i] && (req_op[2*i +: 2] == OP_LR);
            is_sc[i]   = req_valid[i] && (req_op[2*i +: 2] == OP_SC);
            is_st[i]   = req_valid[i] && (req_op[2*i +: 2] == OP_ST);
            sc_ok[i]   = is_sc[i] && valid_q[i] && (tag_q[i] == req_tag[i]);
        end
        // A lower-index hart with an eligible SC to the same granule takes it;
        // whether that hart itself wins or loses to an even lower one, i loses.
        for (int i = 0; i < NUM_HARTS; i++) begin
            sc_win[i] = sc_ok[i];
            for (int j = 0; j < NUM_HARTS; j++) begin
                if (j < i && sc_ok[j] && (req_tag[j] == req_tag[i]))
                    sc_win[i] = 1'b0;
            end
            killer[i] = is_st[i] || sc_win[i];
        end
    end

    // Compute each hart's next reservation: expire, then kill, then LR install
    always_comb begin
        for (int j = 0; j < NUM_HARTS; j++) begin
            foreign_kill[j] = 1'b0;
            for (int i = 0; i < NUM_HARTS; i++) begin
                if (i != j && killer[i] && valid_q[j] && (req_tag[i] == tag_q[j]))
                    foreign_kill[j] = 1'b1;
            end

            valid_d[j] = valid_q[j];
            tag_d[j]   = tag_q[j];
            cnt_d[j]   = cnt_q[j];

            if (TIMEOUT > 0 && valid_q[j]) begin
                cnt_d[j] = cnt_q[j] - CW'(1);
                if (cnt_q[j] == CW'(1) || cnt_q[j] == '0)
                    valid_d[j] = 1'b0;
            end

            if (foreign_kill[j] || is_sc[j] ||
                (is_st[j] && valid_q[j] && (tag_q[j] == req_tag[j])))
                valid_d[j] = 1'b0;

            if (is_lr[j]) begin
                valid_d[j] = 1'b1;
                tag_d[j]   = req_tag[j];
                cnt_d[j]   = CNT_LOAD;
            end
        end
    end

    // Reservation state and registered verdict/conflict outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q        <= '0;
            resp_valid     <= '0;
            sc_success     <= '0;
            conflict_pulse <= '0;
            for (int i = 0; i < NUM_HARTS; i++) begin
                tag_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            valid_q        <= valid_d;
            resp_valid     <= is_sc;
            sc_success     <= sc_win;
            conflict_pulse <= foreign_kill;
            for (int i = 0; i < NUM_HARTS; i++) begin
                tag_q[i] <= tag_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign reserved_flag = valid_q;

endmodule

// File: tb/tb_lrsc_reservation_unit.sv
// Testbench for lrsc_reservation_unit: two harts, 4-cycle reservation lifetime.
module tb_lrsc_reservation_unit;

    localparam int NH = 2;
    localparam int AW = 32;

    localparam logic [1:0] LD = 2'b00;
    localparam logic [1:0] LR = 2'b01;
    localparam logic [1:0] SC = 2'b10;
    localparam logic [1:0] ST = 2'b11;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NH-1:0]  req_valid = '0;
    logic [2*NH-1:0] req_op = '0;
    logic [AW*NH-1:0] req_addr = '0;
    logic [NH-1:0]  resp_valid, sc_success, reserved_flag, conflict_pulse;

    lrsc_reservation_unit #(
        .NUM_HARTS(NH), .ADDR_WIDTH(AW), .GRANULE_BITS(2), .TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
        .resp_valid(resp_valid), .sc_success(sc_success),
        .reserved_flag(reserved_flag), .conflict_pulse(conflict_pulse)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus plus the outputs expected right after its edge
    typedef struct {
        logic        rst;
        logic [1:0]  v;
        logic [1:0]  op1, op0;
        logic [31:0] a1, a0;
        logic [1:0]  resp, succ, resv, conf;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic vec_t mk(logic r, logic [1:0] v, logic [1:0] op1, logic [1:0] op0,
                                logic [31:0] a1, logic [31:0] a0,
                                logic [1:0] resp, logic [1:0] succ,
                                logic [1:0] resv, logic [1:0] conf);
        vec_t t;
        t.rst = r; t.v = v; t.op1 = op1; t.op0 = op0; t.a1 = a1; t.a0 = a0;
        t.resp = resp; t.succ = succ; t.resv = resv; t.conf = conf;
        return t;
    endfunction

    task automatic chk(string nm, int idx, logic [1:0] act, logic [1:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s vec %0d: got %b expected %b", nm, idx, act, exp);
        end
    endtask

    task automatic step(vec_t t, int idx);
        vec_t e;
        @(negedge clk);
        rst       = t.rst;
        req_valid = t.v;
        req_op    = {t.op1, t.op0};
        req_addr  = {t.a1, t.a0};
        sb.push_back(t);
        @(posedge clk);
        #1;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard vec %0d: got empty queue expected entry", idx);
        end else begin
            e = sb.pop_front();
            chk("resp_valid",     idx, resp_valid,     e.resp);
            chk("sc_success",     idx, sc_success,     e.succ);
            chk("reserved_flag",  idx, reserved_flag,  e.resv);
            chk("conflict_pulse", idx, conflict_pulse, e.conf);
        end
    endtask

    initial begin
        //            rst  v     op1 op0 a1       a0       resp   succ   resv   conf
        // reset
        tbl.push_back(mk(1, 2'b00, LD, LD, 32'h0,   32'h0,   2'b00, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b00, LD, LD, 32'h0,   32'h0,   2'b00, 2'b00, 2'b00, 2'b00));
        // LR then SC two cycles later succeeds
        tbl.push_back(mk(0, 2'b01, LD, LR, 32'h0,   32'h100, 2'b00, 2'b00, 2'b01, 2'b00));
        tbl.push_back(mk(0, 2'b00, LD, LD, 32'h0,   32'h0,   2'b00, 2'b00, 2'b01, 2'b00));
        tbl.push_back(mk(0, 2'b01, LD, SC, 32'h0,   32'h100, 2'b01, 2'b01, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b00, LD, LD, 32'h0,   32'h0,   2'b00, 2'b00, 2'b00, 2'b00));
        // foreign store to same word kills
        tbl.push_back(mk(0, 2'b01, LD, LR, 32'h0,   32'h100, 2'b00, 2'b00, 2'b01, 2'b00));
        tbl.push_back(mk(0, 2'b10, ST, LD, 32'h102, 32'h0,   2'b00, 2'b00, 2'b00, 2'b01));
        tbl.push_back(mk(0, 2'b01, LD, SC, 32'h0,   32'h100, 2'b01, 2'b00, 2'b00, 2'b00));
        // simultaneous SCs: hart0 wins, hart1 killed
        tbl.push_back(mk(0, 2'b11, LR, LR, 32'h200, 32'h200, 2'b00, 2'b00, 2'b11, 2'b00));
        tbl.push_back(mk(0, 2'b11, SC, SC, 32'h200, 32'h200, 2'b11, 2'b01, 2'b00, 2'b10));
        tbl.push_back(mk(0, 2'b10, SC, LD, 32'h200, 32'h0,   2'b10, 2'b00, 2'b00, 2'b00));
        // LR beats concurrent foreign store; SC to other word fails
        tbl.push_back(mk(0, 2'b11, ST, LR, 32'h400, 32'h400, 2'b00, 2'b00, 2'b01, 2'b00));
        tbl.push_back(mk(0, 2'b01, LD, SC, 32'h0,   32'h404, 2'b01, 2'b00, 2'b00, 2'b00));
        // reset mid-operation, SC in reset cycle has no response
        tbl.push_back(mk(0, 2'b01, LD, LR, 32'h0,   32'h500, 2'b00, 2'b00, 2'b01, 2'b00));
        tbl.push_back(mk(1, 2'b01, LD, SC, 32'h0,   32'h500, 2'b00, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b01, LD, SC, 32'h0,   32'h500, 2'b01, 2'b00, 2'b00, 2'b00));
        // granule match ignores low address bits
        tbl.push_back(mk(0, 2'b10, LR, LD, 32'h103, 32'h0,   2'b00, 2'b00, 2'b10, 2'b00));
        tbl.push_back(mk(0, 2'b10, SC, LD, 32'h100, 32'h0,   2'b10, 2'b10, 2'b00, 2'b00));
        // own store clears own reservation without conflict
        tbl.push_back(mk(0, 2'b01, LD, LR, 32'h0,   32'h600, 2'b00, 2'b00, 2'b01, 2'b00));
        tbl.push_back(mk(0, 2'b01, LD, ST, 32'h0,   32'h600, 2'b00, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b01, LD, SC, 32'h0,   32'h600, 2'b01, 2'b00, 2'b00, 2'b00));
        // failed SC does not disturb other harts
        tbl.push_back(mk(0, 2'b11, LR, LR, 32'h700, 32'h700, 2'b00, 2'b00, 2'b11, 2'b00));
        tbl.push_back(mk(0, 2'b01, LD, SC, 32'h0,   32'h704, 2'b01, 2'b00, 2'b10, 2'b00));
        tbl.push_back(mk(0, 2'b10, SC, LD, 32'h700, 32'h0,   2'b10, 2'b10, 2'b00, 2'b00));
        // plain load and unstrobed SC have no effect
        tbl.push_back(mk(0, 2'b01, LD, LR, 32'h0,   32'h800, 2'b00, 2'b00, 2'b01, 2'b00));
        tbl.push_back(mk(0, 2'b10, LD, SC, 32'h800, 32'h800, 2'b00, 2'b00, 2'b01, 2'b00));
        tbl.push_back(mk(0, 2'b01, LD, SC, 32'h0,   32'h800, 2'b01, 2'b01, 2'b00, 2'b00));
        // re-LR concurrent with foreign store: old one killed, new one installed
        tbl.push_back(mk(0, 2'b01, LD, LR, 32'h0,   32'h900, 2'b00, 2'b00, 2'b01, 2'b00));
        tbl.push_back(mk(0, 2'b11, ST, LR, 32'h900, 32'h900, 2'b00, 2'b00, 2'b01, 2'b01));
        tbl.push_back(mk(0, 2'b01, LD, SC, 32'h0,   32'h900, 2'b01, 2'b01, 2'b00, 2'b00));

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i], i);

        // Lifetime: flag high for exactly 4 cycles after LR, then SC fails
        step(mk(0, 2'b10, LR, LD, 32'h300, 32'h0, 2'b00, 2'b00, 2'b10, 2'b00), 100);
        for (int k = 0; k < 4; k++)
            step(mk(0, 2'b00, LD, LD, 32'h0, 32'h0, 2'b00, 2'b00,
                    (k < 3) ? 2'b10 : 2'b00, 2'b00), 101 + k);
        step(mk(0, 2'b10, SC, LD, 32'h300, 32'h0, 2'b10, 2'b00, 2'b00, 2'b00), 105);

        // Re-issuing LR reloads the lifetime
        step(mk(0, 2'b10, LR, LD, 32'h310, 32'h0, 2'b00, 2'b00, 2'b10, 2'b00), 110);
        step(mk(0, 2'b00, LD, LD, 32'h0,   32'h0, 2'b00, 2'b00, 2'b10, 2'b00), 111);
        step(mk(0, 2'b00, LD, LD, 32'h0,   32'h0, 2'b00, 2'b00, 2'b10, 2'b00), 112);
        step(mk(0, 2'b10, LR, LD, 32'h310, 32'h0, 2'b00, 2'b00, 2'b10, 2'b00), 113);
        step(mk(0, 2'b00, LD, LD, 32'h0,   32'h0, 2'b00, 2'b00, 2'b10, 2'b00), 114);
        step(mk(0, 2'b00, LD, LD, 32'h0,   32'h0, 2'b00, 2'b00, 2'b10, 2'b00), 115);
        step(mk(0, 2'b10, SC, LD, 32'h310, 32'h0, 2'b10, 2'b10, 2'b00, 2'b00), 116);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lrsc_reservation_unit.md
# lrsc_reservation_unit

Multi-hart reservation tracker for RISC-V LR/SC atomics. It sits beside the data-memory port and consumes per-hart memory requests decoded by the control unit (atomic_flag / reserved_flag path). It maintains one reservation per hart at configurable granule size and returns a registered SC success/fail verdict one cycle after each SC. Reservations are cleared by conflicting stores, by successful SCs from other harts, by timeout, and by reset.

## Interface
- NUM_HARTS, 2, number of independent request channels (1..8)
- ADDR_WIDTH, 32, byte-address width
- GRANULE_BITS, 2, low address bits ignored for reservation match (2 = word granule)
- TIMEOUT, 64, reservation lifetime in cycles; 0 disables timeout
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  NUM_HARTS  per-hart request strobe
- req_op  input  2*NUM_HARTS  per hart: 00 plain load, 01 LR, 10 SC, 11 store/AMO write
- req_addr  input  ADDR_WIDTH*NUM_HARTS  per-hart byte address
- resp_valid  output  NUM_HARTS  one-cycle pulse, SC verdict valid
- sc_success  output  NUM_HARTS  1 = SC may write memory, 0 = SC failed (valid with resp_valid)
- reserved_flag  output  NUM_HARTS  hart currently holds a valid reservation
- conflict_pulse  output  NUM_HARTS  hart's reservation was killed by another hart this cycle

## Operation
- Per-hart state: valid bit, tag = req_addr[ADDR_WIDTH-1:GRANULE_BITS], down-counter of width clog2(TIMEOUT+1).
- Granule match: tags equal; addresses differing only in low GRANULE_BITS match.
- LR (01): sets own valid=1, tag=granule, counter=TIMEOUT; overwrites any prior own reservation.
- SC (10): succeeds iff own valid=1 and tag matches, and no lower-index hart wins the same granule this cycle. Own reservation cleared whether success or fail.
- Simultaneous successful SCs to one granule: lowest hart index succeeds; others fail.
- Successful SC or store (11) from hart i to granule G clears reservation of every hart j≠i with tag G; sets conflict_pulse[j] if it was valid. Store from hart i to own reserved granule also clears own reservation (no conflict_pulse).
- Failed SC does not invalidate anyone else.
- Plain load (00) or req_valid=0: no effect.
- Same-cycle ordering: kills from this cycle's stores/successful SCs apply to reservations existing at cycle start; an LR in the same cycle then installs its new reservation (LR wins over concurrent foreign store).
- Timeout: counter decrements each cycle while valid; on reaching 0 valid clears. TIMEOUT=0: no decrement, no expiry. Counter reloads only on LR.

## Timing
- All outputs registered. Reset values: resp_valid=0, sc_success=0, reserved_flag=0, conflict_pulse=0; all valid bits and counters 0.
- SC presented cycle N -> resp_valid/sc_success in cycle N+1 (one-cycle pulse, held for no more than one cycle).
- LR cycle N -> reserved_flag=1 in N+1; kill in cycle N -> reserved_flag=0 and conflict_pulse=1 in N+1.
- LR in cycle N with TIMEOUT=T -> reserved_flag high for exactly T cycles (N+1..N+T) absent other events.
- Back-to-back requests every cycle per hart supported; no stall, no backpressure.
- rst asserted mid-operation: next edge clears all state; an SC in the reset cycle produces no response.

## Test plan
- Hart0 LR 0x100, SC 0x100 two cycles later -> resp_valid[0]=1, sc_success[0]=1 one cycle after SC; reserved_flag[0]=0 afterwards.
- Hart0 LR 0x100; hart1 store 0x102 (same word) -> conflict_pulse[0]=1, reserved_flag[0]=0; hart0 SC 0x100 -> sc_success[0]=0.
- Hart0 and hart1 both LR 0x200, both SC 0x200 same cycle -> sc_success[0]=1, sc_success[1]=0; hart1 reservation gone.
- TIMEOUT=4: hart1 LR 0x300, idle 4 cycles -> reserved_flag[1] drops exactly 4 cycles after rising; SC -> sc_success[1]=0.
- Hart0 LR 0x400 same cycle as hart1 store 0x400 -> reserved_flag[0]=1; hart0 SC 0x404 (different word) -> fail, reservation cleared.
- Hart0 LR 0x500, rst for one cycle, SC 0x500 -> all outputs 0 during/after reset, sc_success[0]=0.
